// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C register-file target.
// State encoding, filter default, bus ACK levels, pointer stepping.
package i2c_tgt_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_e;

  localparam int FILTER_LEN_DEF = 4;

  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;

  // Last implemented register wraps to 0; anything else steps mod 256.
  function automatic logic [7:0] ptr_next(
    input logic [7:0] p,
    input int         n
  );
    return (32'(p) == 32'(n - 1)) ? 8'h00 : p + 8'h01;
  endfunction

endpackage

// File: rtl/i2c_tgt_filter.sv
// SCL/SDA 2-flop synchroniser, glitch filter and bus event detector.
// In: clk, rst, scl_i, sda_i. Out: sda (filtered), scl_rise/fall, start, stop.
module i2c_tgt_filter
  import i2c_tgt_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  // Bit 0 = SCL, bit 1 = SDA.
  logic [1:0]    s1_q, s1_d;
  logic [1:0]    s2_q, s2_d;
  logic [1:0]    filt_q, filt_d;
  logic [1:0]    prev_q, prev_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  always_comb begin
    s1_d   = {sda_i, scl_i};
    s2_d   = s1_q;
    prev_d = filt_q;
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      // New level must be seen FILTER_LEN times in a row.
      if (s2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
          filt_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 2'b11;
      s2_q     <= 2'b11;
      filt_q   <= 2'b11;
      prev_q   <= 2'b11;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      filt_q   <= filt_d;
      prev_q   <= prev_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign sda      = filt_q[1];
  assign scl_rise = filt_q[0] & ~prev_q[0];
  assign scl_fall = ~filt_q[0] & prev_q[0];
  assign start    = filt_q[0] & prev_q[0] & prev_q[1] & ~filt_q[1];
  assign stop     = filt_q[0] & prev_q[0] & ~prev_q[1] & filt_q[1];

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an 8-bit register file, pointer auto-increment.
// Pins scl_*/sda_*; local loc_wr_*/loc_rd_*; host-write strobe bus_wr_*; busy.
module i2c_target_regs
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0]            DEV_ADDR   = 7'h68,
  parameter int                    NUM_REGS   = 32,
  parameter logic [NUM_REGS*8-1:0] RESET_VAL  = '0,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter int                    FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_t,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  input  logic       loc_wr_en,
  input  logic [7:0] loc_wr_addr,
  input  logic [7:0] loc_wr_data,
  input  logic [7:0] loc_rd_addr,
  output logic [7:0] loc_rd_data,
  output logic       bus_wr_valid,
  output logic [7:0] bus_wr_addr,
  output logic [7:0] bus_wr_data,
  output logic       busy
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic sda_f, scl_rise, scl_fall, start, stop;

  i2c_tgt_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda_f),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] rd_q, rd_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_t_q, sda_t_d;
  logic       busy_q, busy_d;
  logic       phase_q, phase_d;
  logic       rw_q, rw_d;
  logic       hack_q, hack_d;
  logic       wv_q, wv_d;
  logic [7:0] wa_q, wa_d;
  logic [7:0] wd_q, wd_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

  logic [7:0]    byte_in, rd_sel;
  logic [IW-1:0] ptr_idx, loc_idx;
  logic          ptr_ok, loc_ok, byte_end, load_rd;

  assign byte_in  = {shift_q, sda_f};
  assign byte_end = scl_rise && (bit_cnt_q == 3'd7);
  assign ptr_idx  = ptr_q[IW-1:0];
  assign loc_idx  = loc_wr_addr[IW-1:0];
  assign ptr_ok   = {1'b0, ptr_q} < 9'(NUM_REGS);
  assign loc_ok   = {1'b0, loc_wr_addr} < 9'(NUM_REGS);
  assign rd_sel   = ptr_ok ? regs_q[ptr_idx] : 8'h00;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rd_d      = rd_q;
    ptr_d     = ptr_q;
    sda_t_d   = sda_t_q;
    busy_d    = busy_q;
    phase_d   = phase_q;
    rw_d      = rw_q;
    hack_d    = hack_q;
    wv_d      = 1'b0;
    wa_d      = wa_q;
    wd_d      = wd_q;
    regs_d    = regs_q;
    load_rd   = 1'b0;

    if (start) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      sda_t_d   = 1'b1;
      phase_d   = 1'b0;
    end else if (stop) begin
      state_d = ST_IDLE;
      sda_t_d = 1'b1;
      busy_d  = 1'b0;
      phase_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (byte_end) begin
            unique case (1'b1)
              state_q == ST_ADDR: begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = byte_in[0];
                end else begin
                  state_d = ST_IGNORE;
                  busy_d  = 1'b0;
                end
              end
              state_q == ST_PTR: begin
                ptr_d   = byte_in;
                state_d = ST_PTR_ACK;
              end
              default: begin
                // Every host data byte is strobed; RO/out-of-range are dropped.
                wv_d  = 1'b1;
                wa_d  = ptr_q;
                wd_d  = byte_in;
                ptr_d = ptr_next(ptr_q, NUM_REGS);
                if (ptr_ok && !RO_MASK[ptr_idx]) begin
                  regs_d[ptr_idx] = byte_in;
                end
                state_d = ST_WDATA_ACK;
              end
            endcase
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          // First fall starts the ACK slot, second fall ends it.
          if (scl_fall) begin
            if (!phase_q) begin
              sda_t_d = ACK_LVL;
              phase_d = 1'b1;
            end else begin
              sda_t_d   = 1'b1;
              phase_d   = 1'b0;
              bit_cnt_d = 3'd0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                load_rd = 1'b1;
              end else if (state_q == ST_ADDR_ACK) begin
                state_d = ST_PTR;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = ST_RDATA_ACK;
            end
          end else if (scl_fall) begin
            rd_d    = {rd_q[6:0], rd_q[7]};
            sda_t_d = rd_q[6];
          end
        end
        ST_RDATA_ACK: begin
          if (scl_fall && !phase_q) begin
            sda_t_d = NACK_LVL;
            phase_d = 1'b1;
          end else if (scl_rise) begin
            hack_d = (sda_f == ACK_LVL);
          end else if (scl_fall) begin
            phase_d = 1'b0;
            if (hack_q) begin
              load_rd = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        default: begin
        end
      endcase
    end

    // Snapshot isolates the byte on the wire from later local writes.
    if (load_rd) begin
      state_d   = ST_RDATA;
      bit_cnt_d = 3'd0;
      rd_d      = rd_sel;
      sda_t_d   = rd_sel[7];
      ptr_d     = ptr_next(ptr_q, NUM_REGS);
    end

    // Local side applied last so it wins a same-cycle collision.
    if (loc_wr_en && loc_ok) begin
      regs_d[loc_idx] = loc_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 7'd0;
      rd_q      <= 8'd0;
      ptr_q     <= 8'd0;
      sda_t_q   <= 1'b1;
      busy_q    <= 1'b0;
      phase_q   <= 1'b0;
      rw_q      <= 1'b0;
      hack_q    <= 1'b0;
      wv_q      <= 1'b0;
      wa_q      <= 8'd0;
      wd_q      <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL[8*i +: 8];
      end
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rd_q      <= rd_d;
      ptr_q     <= ptr_d;
      sda_t_q   <= sda_t_d;
      busy_q    <= busy_d;
      phase_q   <= phase_d;
      rw_q      <= rw_d;
      hack_q    <= hack_d;
      wv_q      <= wv_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      regs_q    <= regs_d;
    end
  end

  assign scl_o        = 1'b0;
  assign scl_t        = 1'b1;
  assign sda_o        = 1'b0;
  assign sda_t        = sda_t_q;
  assign busy         = busy_q;
  assign bus_wr_valid = wv_q;
  assign bus_wr_addr  = wa_q;
  assign bus_wr_data  = wd_q;

  assign loc_rd_data = ({1'b0, loc_rd_addr} < 9'(NUM_REGS))
                     ? regs_q[loc_rd_addr[IW-1:0]] : 8'h00;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C host plus register-map model.
// Scoreboards host writes, read data, ACKs, SDA release and local reads.
module tb_i2c_target_regs;

  localparam int NR = 32;
  localparam int FL = 4;
  localparam int Q  = 12;

  function automatic logic [NR*8-1:0] mk_rst();
    logic [NR*8-1:0] v;
    for (int i = 0; i < NR; i++) v[8*i +: 8] = 8'((i * 7 + 64) & 255);
    return v;
  endfunction

  localparam logic [NR*8-1:0] RV = mk_rst();
  localparam logic [NR-1:0]   RO = 32'h0000_0004;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_scl = 1'b1;
  logic       host_sda = 1'b1;
  logic       scl_pin, sda_pin;
  logic       scl_o, scl_t, sda_o, sda_t;
  logic       loc_wr_en = 1'b0;
  logic [7:0] loc_wr_addr = 8'h00;
  logic [7:0] loc_wr_data = 8'h00;
  logic [7:0] loc_rd_addr = 8'h00;
  logic [7:0] loc_rd_data;
  logic       bus_wr_valid;
  logic [7:0] bus_wr_addr, bus_wr_data;
  logic       busy;

  always #5 clk = ~clk;

  assign scl_pin = host_scl;
  assign sda_pin = host_sda & (sda_t | sda_o);

  i2c_target_regs #(
    .DEV_ADDR   (7'h68),
    .NUM_REGS   (NR),
    .RESET_VAL  (RV),
    .RO_MASK    (RO),
    .FILTER_LEN (FL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .scl_i        (scl_pin),
    .scl_o        (scl_o),
    .scl_t        (scl_t),
    .sda_i        (sda_pin),
    .sda_o        (sda_o),
    .sda_t        (sda_t),
    .loc_wr_en    (loc_wr_en),
    .loc_wr_addr  (loc_wr_addr),
    .loc_wr_data  (loc_wr_data),
    .loc_rd_addr  (loc_rd_addr),
    .loc_rd_data  (loc_rd_data),
    .bus_wr_valid (bus_wr_valid),
    .bus_wr_addr  (bus_wr_addr),
    .bus_wr_data  (bus_wr_data),
    .busy         (busy)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] m_regs [NR];
  logic [7:0] m_ptr;
  wr_t        exp_q [$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         n_push = 0;
  int         n_pulse = 0;
  bit         drive_ok = 1'b0;
  bit         quiet = 1'b0;
  logic [7:0] got [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_rd(input int a);
    return (a < NR) ? m_regs[a] : 8'h00;
  endfunction

  function automatic logic [7:0] m_next(input logic [7:0] p);
    return (int'(p) == NR - 1) ? 8'h00 : 8'((int'(p) + 1) % 256);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = RV[8*i +: 8];
    m_ptr = 8'h00;
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (!drive_ok) chk("sda_released", sda_t, 1);
        chk("pins_const", {scl_o, scl_t, sda_o}, 3'b010);
        if (bus_wr_valid) begin
          n_pulse++;
          if (exp_q.size() == 0) begin
            chk("wr_unexpected", bus_wr_valid, 0);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", bus_wr_addr, e.a);
            chk("wr_data", bus_wr_data, e.d);
          end
        end
        if (quiet) chk("loc_rd", loc_rd_data, m_rd(int'(loc_rd_addr)));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic i2c_start();
    host_sda = 1'b1; wq(Q);
    host_scl = 1'b1; wq(Q);
    host_sda = 1'b0; wq(Q);
    host_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wq(Q); host_sda = 1'b0;
    wq(Q); host_scl = 1'b1;
    wq(Q); host_sda = 1'b1;
    wq(2 * Q);
    chk("busy_after_stop", busy, 0);
  endtask

  task automatic bit_io(input logic b, input bit glitch, output logic s);
    wq(Q); host_sda = b;
    wq(Q); host_scl = 1'b1;
    wq(Q); s = sda_pin;
    if (glitch) begin
      host_sda = ~b; wq(FL - 1);
      host_sda = b;  wq(Q - (FL - 1));
    end else begin
      wq(Q);
    end
    host_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_ack,
                           input bit keep, input bit glitch);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && exp_ack) drive_ok = 1'b1;
      bit_io(b[i], glitch && (i == 4 || i == 3), s);
    end
    bit_io(1'b1, 1'b0, s);
    chk("ack_bit", s, exp_ack ? 0 : 1);
    if (!keep) begin
      wq(Q);
      drive_ok = 1'b0;
    end
  endtask

  task automatic recv_byte(input bit host_ack, output logic [7:0] r);
    logic s;
    drive_ok = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, 1'b0, s);
      r[i] = s;
    end
    bit_io(~host_ack, 1'b0, s);
    if (!host_ack) begin
      wq(Q);
      drive_ok = 1'b0;
    end
  endtask

  task automatic wr_txn(input logic [7:0] p, input logic [7:0] d [4],
                        input int n, input bit glitch);
    i2c_start();
    send_byte(8'hD0, 1'b1, 1'b0, 1'b0);
    chk("busy_on_match", busy, 1);
    send_byte(p, 1'b1, 1'b0, 1'b0);
    m_ptr = p;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({m_ptr, d[k]});
      n_push++;
      send_byte(d[k], 1'b1, 1'b0, glitch);
      if (int'(m_ptr) < NR && !RO[m_ptr[4:0]]) m_regs[m_ptr[4:0]] = d[k];
      m_ptr = m_next(m_ptr);
    end
    i2c_stop();
  endtask

  task automatic rd_txn(input int n);
    logic [7:0] r;
    i2c_start();
    send_byte(8'hD1, 1'b1, 1'b1, 1'b0);
    chk("busy_on_read", busy, 1);
    for (int k = 0; k < n; k++) begin
      recv_byte(k != n - 1, r);
      chk("rd_byte", r, m_rd(int'(m_ptr)));
      got[k] = r;
      m_ptr = m_next(m_ptr);
    end
    i2c_stop();
  endtask

  task automatic sweep();
    quiet = 1'b1;
    for (int a = 0; a < NR + 3; a++) begin
      loc_rd_addr = 8'(a);
      wq(1);
    end
    loc_rd_addr = 8'hFF;
    wq(1);
    quiet = 1'b0;
  endtask

  task automatic loc_wr(input logic [7:0] a, input logic [7:0] d);
    loc_wr_addr = a;
    loc_wr_data = d;
    loc_wr_en   = 1'b1;
    wq(1);
    loc_wr_en   = 1'b0;
    if (int'(a) < NR) m_regs[a[4:0]] = d;
  endtask

  task automatic peek(input string nm, input logic [7:0] a,
                      input logic [7:0] exp);
    loc_rd_addr = a;
    #1;
    chk(nm, loc_rd_data, exp);
  endtask

  logic [7:0] dv [4];

  initial begin
    m_reset();
    wq(5);
    rst = 1'b0;
    wq(2);
    chk("rst_sda_t", sda_t, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wv", bus_wr_valid, 0);
    chk("rst_wa", bus_wr_addr, 0);
    chk("rst_wd", bus_wr_data, 0);
    peek("rst_reg0", 8'h00, 8'h40);
    sweep();

    dv = '{8'hA5, 8'h3C, 8'h00, 8'h00};
    wr_txn(8'h05, dv, 2, 1'b0);
    peek("reg5", 8'h05, 8'hA5);
    peek("reg6", 8'h06, 8'h3C);
    sweep();

    i2c_start();
    send_byte(8'hD0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h10, 1'b1, 1'b0, 1'b0);
    m_ptr = 8'h10;
    rd_txn(3);
    chk("rd10", got[0], 8'hB0);
    chk("rd11", got[1], 8'hB7);
    chk("rd12", got[2], 8'hBE);
    rd_txn(1);
    chk("rd13_ptr_kept", got[0], 8'hC5);

    i2c_start();
    send_byte(8'h6A, 1'b0, 1'b0, 1'b0);
    chk("busy_mismatch", busy, 0);
    i2c_stop();
    sweep();

    dv = '{8'hFF, 8'h00, 8'h00, 8'h00};
    wr_txn(8'h02, dv, 1, 1'b0);
    peek("ro_reg2_kept", 8'h02, 8'h4E);
    loc_wr(8'h02, 8'h11);
    peek("loc_reg2", 8'h02, 8'h11);
    loc_wr(8'd40, 8'h99);
    sweep();

    dv = '{8'h00, 8'h00, 8'h00, 8'h00};
    wr_txn(8'h1F, dv, 0, 1'b0);
    rd_txn(2);
    chk("wrap31", got[0], 8'h19);
    chk("wrap0", got[1], 8'h40);

    dv = '{8'h96, 8'h00, 8'h00, 8'h00};
    wr_txn(8'h07, dv, 1, 1'b1);
    peek("glitch_reg7", 8'h07, 8'h96);
    sweep();

    i2c_start();
    send_byte(8'hD0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0, 1'b0);
    i2c_start();
    send_byte(8'hD1, 1'b1, 1'b1, 1'b0);
    wq(Q);
    chk("rd_drive0", sda_t, 0);
    rst = 1'b1;
    wq(1);
    #2;
    chk("rst_mid_release", sda_t, 1);
    drive_ok = 1'b0;
    host_sda = 1'b1;
    host_scl = 1'b1;
    m_reset();
    wq(4);
    rst = 1'b0;
    wq(3 * Q);
    chk("rst2_busy", busy, 0);
    peek("rst2_reg5", 8'h05, 8'h63);
    sweep();
    dv = '{8'h77, 8'h00, 8'h00, 8'h00};
    wr_txn(8'h08, dv, 1, 1'b0);
    peek("post_rst_reg8", 8'h08, 8'h77);
    sweep();

    wq(4);
    chk("wr_queue_empty", exp_q.size(), 0);
    chk("wr_pulse_count", n_pulse, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
